// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared types and sizing for the shift-add multiplier controller
package mul_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W = $clog2(WIDTH_DEF);
endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// shift_add_mul_ctrl_if: two request channels and one response channel
interface shift_add_mul_ctrl_if #(parameter int WIDTH = 4);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [2*WIDTH-1:0] resp_product;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_product
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_product
    );
endinterface

// File: rtl/shift_add_step.sv
// shift_add_step: one add-with-carry and right-shift step of the multiplier
module shift_add_step #(parameter int WIDTH = 4) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   a,
    output logic [2*WIDTH-1:0] p_next
);
    logic [WIDTH:0] h;
    always_comb begin
        h = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? a : {WIDTH{1'b0}})};
        p_next = {h, p[WIDTH-1:1]};
    end
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: round-robin shared iterative shift-add multiplier
module shift_add_mul_ctrl
    import mul_ctrl_pkg::*;
#(parameter int WIDTH = WIDTH_DEF) (
    input logic               clk,
    input logic               reset,
    shift_add_mul_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p, p_next, product;
    logic               id, last_grant, grant, hs, last_step;
    shift_add_step #(.WIDTH(WIDTH)) u_step (.p(p), .a(a_q), .p_next(p_next));
    // ready is gated by reset so every output reads 0 while reset is held
    always_comb begin
        grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        hs = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
        last_step = count == CW'(WIDTH - 1);
        state_next = state == IDLE ? (hs ? ITER : IDLE) :
                     state == ITER ? (last_step ? DONE : ITER) :
                     (bus.resp_ready ? IDLE : DONE);
        bus.req0_ready = hs && !grant;
        bus.req1_ready = hs && grant;
        bus.resp_valid = state == DONE;
        bus.resp_id = id;
        bus.resp_product = product;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            a_q <= '0;
            p <= '0;
            product <= '0;
            id <= 1'b0;
            last_grant <= 1'b1;
        end else if (hs) begin
            a_q <= grant ? bus.req1_a : bus.req0_a;
            p <= {{WIDTH{1'b0}}, (grant ? bus.req1_b : bus.req0_b)};
            count <= '0;
            id <= grant;
            last_grant <= grant;
        end else if (state == ITER) begin
            p <= p_next;
            count <= count + 1'b1;
            if (last_step) product <= p_next;
        end
    end
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb_shift_add_mul_ctrl: directed vector and corner-sequence bench for the shared multiplier
module tb_shift_add_mul_ctrl;
    typedef struct {
        logic       sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[8];
    always #5 clk = ~clk;
    shift_add_mul_ctrl_if #(.WIDTH(4)) bus ();
    shift_add_mul_ctrl #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.resp_ready = 1;
    endtask

    task automatic wait_ready(output logic who, output logic ok);
        int n = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        ok = bus.req0_ready || bus.req1_ready;
        who = bus.req1_ready;
    endtask

    task automatic wait_resp(output int e);
        e = 0;
        while (!bus.resp_valid && e < 30) begin
            @(negedge clk); e++;
        end
    endtask

    task automatic do_op(input logic sel, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input string nm);
        logic who, ok;
        int e;
        @(negedge clk);
        if (sel) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; end
        else begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; end
        wait_ready(who, ok);
        check({nm, " ready"}, 16'(ok), 16'(1));
        check({nm, " grant"}, 16'(who), 16'(sel));
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clk);
        wait_resp(e);
        check({nm, " latency"}, 16'(e), 16'(4));
        check({nm, " product"}, 16'(bus.resp_product), 16'(exp));
        check({nm, " id"}, 16'(bus.resp_id), 16'(sel));
        @(negedge clk);
        check({nm, " valid_drop"}, 16'(bus.resp_valid), 16'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic who, ok;
        int e;
        idle_inputs();
        vecs[0] = '{1'b0, 4'd7,  4'd7,  8'h31};
        vecs[1] = '{1'b1, 4'd15, 4'd15, 8'hE1};
        vecs[2] = '{1'b0, 4'd0,  4'd9,  8'h00};
        vecs[3] = '{1'b1, 4'd9,  4'd0,  8'h00};
        vecs[4] = '{1'b0, 4'd1,  4'd1,  8'h01};
        vecs[5] = '{1'b1, 4'd15, 4'd1,  8'h0F};
        vecs[6] = '{1'b0, 4'd8,  4'd12, 8'h60};
        vecs[7] = '{1'b1, 4'd13, 4'd11, 8'h8F};
        #12;
        check("rst valid", 16'(bus.resp_valid), 16'(0));
        check("rst id", 16'(bus.resp_id), 16'(0));
        check("rst product", 16'(bus.resp_product), 16'(0));
        check("rst readys", 16'({bus.req0_ready, bus.req1_ready}), 16'(0));
        @(negedge clk); reset = 0;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));

        // both requesters held valid after reset alternate 0,1,0,1
        pulse_reset();
        bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 5;
        bus.req1_valid = 1; bus.req1_a = 6; bus.req1_b = 2;
        for (int i = 0; i < 4; i++) begin
            wait_ready(who, ok);
            check($sformatf("rr%0d ready", i), 16'(ok), 16'(1));
            check($sformatf("rr%0d grant", i), 16'(who), 16'(i % 2));
            check($sformatf("rr%0d both_ready", i), 16'(bus.req0_ready & bus.req1_ready), 16'(0));
            @(posedge clk);
            @(negedge clk);
            wait_resp(e);
            check($sformatf("rr%0d latency", i), 16'(e), 16'(4));
            check($sformatf("rr%0d id", i), 16'(bus.resp_id), 16'(i % 2));
            check($sformatf("rr%0d product", i), 16'(bus.resp_product), (i % 2) ? 16'(12) : 16'(15));
            check($sformatf("rr%0d done_readys", i), 16'(bus.req0_ready | bus.req1_ready), 16'(0));
        end
        bus.req0_valid = 0; bus.req1_valid = 0;

        // consumer stalls in DONE: response must hold, no new grants
        @(negedge clk);
        bus.resp_ready = 0;
        bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 13;
        wait_ready(who, ok);
        check("stall grant", 16'({ok, who}), 16'(2));
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(negedge clk);
        wait_resp(e);
        check("stall latency", 16'(e), 16'(4));
        bus.req1_valid = 1; bus.req1_a = 2; bus.req1_b = 3;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d valid", k), 16'(bus.resp_valid), 16'(1));
            check($sformatf("stall%0d product", k), 16'(bus.resp_product), 16'(8'h41));
            check($sformatf("stall%0d id", k), 16'(bus.resp_id), 16'(0));
            check($sformatf("stall%0d readys", k), 16'({bus.req0_ready, bus.req1_ready}), 16'(0));
            @(negedge clk);
        end
        bus.resp_ready = 1;
        @(negedge clk); #1;
        check("release valid", 16'(bus.resp_valid), 16'(0));
        check("release idle_ready", 16'(bus.req1_ready), 16'(1));
        check("release product_hold", 16'(bus.resp_product), 16'(8'h41));
        bus.req1_valid = 0;

        // reset in the middle of ITER aborts and re-favours req0
        @(negedge clk);
        bus.req1_valid = 1; bus.req1_a = 4; bus.req1_b = 4;
        wait_ready(who, ok);
        check("abort grant", 16'({ok, who}), 16'(3));
        @(posedge clk); #1;
        bus.req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_a = 9; bus.req0_b = 11;
        bus.req1_valid = 1; bus.req1_a = 7; bus.req1_b = 3;
        reset = 1;
        #1;
        check("abort valid", 16'(bus.resp_valid), 16'(0));
        check("abort id", 16'(bus.resp_id), 16'(0));
        check("abort product", 16'(bus.resp_product), 16'(0));
        check("abort readys", 16'({bus.req0_ready, bus.req1_ready}), 16'(0));
        @(negedge clk); reset = 0;
        wait_ready(who, ok);
        check("post_rst grant", 16'({ok, who}), 16'(2));
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clk);
        wait_resp(e);
        check("post_rst latency", 16'(e), 16'(4));
        check("post_rst product", 16'(bus.resp_product), 16'(8'h63));
        check("post_rst id", 16'(bus.resp_id), 16'(0));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
